// File: rtl/mouse_packet_decoder_if.sv
// Byte-in / decoded-packet-out bundle between the PS/2 byte receiver, the
// mouse packet decoder and the display logic.
interface mouse_packet_decoder_if #(
    parameter int XW = 10,
    parameter int YW = 9
);
    logic [7:0]    i_byte;
    logic          i_byte_valid;
    logic [2:0]    o_buttons;
    logic [8:0]    o_dx;
    logic [8:0]    o_dy;
    logic          o_packet_valid;
    logic [XW-1:0] o_cursor_x;
    logic [YW-1:0] o_cursor_y;
    logic          o_sync_err;
    logic          o_timeout;

    modport master (
        output i_byte, i_byte_valid,
        input  o_buttons, o_dx, o_dy, o_packet_valid,
        input  o_cursor_x, o_cursor_y, o_sync_err, o_timeout
    );

    modport slave (
        input  i_byte, i_byte_valid,
        output o_buttons, o_dx, o_dy, o_packet_valid,
        output o_cursor_x, o_cursor_y, o_sync_err, o_timeout
    );
endinterface

// File: rtl/mouse_packet_decoder.sv
// Assembles 3-byte PS/2 mouse packets, decodes buttons and 9-bit deltas,
// and tracks a clamped on-screen cursor position.
module mouse_packet_decoder #(
    parameter int SCREEN_W       = 640,
    parameter int SCREEN_H       = 480,
    parameter int INIT_X         = 320,
    parameter int INIT_Y         = 240,
    parameter int TIMEOUT_CYCLES = 2000
) (
    input  logic                  i_driver_clk,
    input  logic                  rst_n,
    mouse_packet_decoder_if.slave bus
);
    localparam int XW = $clog2(SCREEN_W);
    localparam int YW = $clog2(SCREEN_H);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int MW = (XW > YW) ? XW : YW;
    localparam int CW = ((MW > 9) ? MW : 9) + 2;

    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] X_MAX  = CW'(SCREEN_W - 1);
    localparam logic [CW-1:0] Y_MAX  = CW'(SCREEN_H - 1);

    typedef enum logic [1:0] {
        WAIT_B0,
        WAIT_B1,
        WAIT_B2,
        UPDATE
    } state_t;

    state_t        state_q, state_d;
    logic          valid_prev_q;
    logic [TW-1:0] tcnt_q, tcnt_d;
    // Header byte minus its always-one sync bit: {yovf, xovf, ysign, xsign, btn[2:0]}
    logic [6:0]    hdr_q, hdr_d;
    logic [7:0]    b1_q, b1_d;
    logic [7:0]    b2_q, b2_d;
    logic [2:0]    buttons_q, buttons_d;
    logic [8:0]    dx_q, dx_d;
    logic [8:0]    dy_q, dy_d;
    logic          pv_q, pv_d;
    logic          sync_q, sync_d;
    logic          to_q, to_d;
    logic [XW-1:0] cx_q, cx_d;
    logic [YW-1:0] cy_q, cy_d;

    logic          rise;
    logic [8:0]    pkt_dx;
    logic [8:0]    pkt_dy;
    logic [CW-1:0] nx;
    logic [CW-1:0] ny;
    logic [XW-1:0] nx_clamped;
    logic [YW-1:0] ny_clamped;

    assign rise = bus.i_byte_valid & ~valid_prev_q;

    // Decode from the stored bytes; only committed to the outputs when leaving UPDATE.
    assign pkt_dx = hdr_q[5] ? 9'd0 : {hdr_q[3], b1_q};
    assign pkt_dy = hdr_q[6] ? 9'd0 : {hdr_q[4], b2_q};

    // Two's-complement sums in CW bits; the MSB is the sign of the result.
    assign nx = {{(CW-XW){1'b0}}, cx_q} + {{(CW-9){pkt_dx[8]}}, pkt_dx};
    assign ny = {{(CW-YW){1'b0}}, cy_q} - {{(CW-9){pkt_dy[8]}}, pkt_dy};

    always_comb begin
        nx_clamped = nx[XW-1:0];
        if (nx[CW-1]) begin
            nx_clamped = '0;
        end else if (nx > X_MAX) begin
            nx_clamped = X_MAX[XW-1:0];
        end
    end

    always_comb begin
        ny_clamped = ny[YW-1:0];
        if (ny[CW-1]) begin
            ny_clamped = '0;
        end else if (ny > Y_MAX) begin
            ny_clamped = Y_MAX[YW-1:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        tcnt_d    = tcnt_q;
        hdr_d     = hdr_q;
        b1_d      = b1_q;
        b2_d      = b2_q;
        buttons_d = buttons_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        cx_d      = cx_q;
        cy_d      = cy_q;
        pv_d      = 1'b0;
        sync_d    = 1'b0;
        to_d      = 1'b0;

        case (state_q)
            WAIT_B0, UPDATE: begin
                tcnt_d = '0;
                if (state_q == UPDATE) begin
                    buttons_d = hdr_q[2:0];
                    dx_d      = pkt_dx;
                    dy_d      = pkt_dy;
                    cx_d      = nx_clamped;
                    cy_d      = ny_clamped;
                    pv_d      = 1'b1;
                    state_d   = WAIT_B0;
                end
                // A fresh strobe edge here starts the next packet without loss.
                if (rise) begin
                    if (bus.i_byte[3]) begin
                        hdr_d   = {bus.i_byte[7:4], bus.i_byte[2:0]};
                        state_d = WAIT_B1;
                    end else begin
                        sync_d  = 1'b1;
                    end
                end
            end

            WAIT_B1: begin
                if (rise) begin
                    b1_d    = bus.i_byte;
                    tcnt_d  = '0;
                    state_d = WAIT_B2;
                end else if (tcnt_q == T_LAST) begin
                    hdr_d   = '0;
                    tcnt_d  = '0;
                    to_d    = 1'b1;
                    state_d = WAIT_B0;
                end else begin
                    tcnt_d  = tcnt_q + 1'b1;
                end
            end

            WAIT_B2: begin
                if (rise) begin
                    b2_d    = bus.i_byte;
                    tcnt_d  = '0;
                    state_d = UPDATE;
                end else if (tcnt_q == T_LAST) begin
                    hdr_d   = '0;
                    b1_d    = '0;
                    tcnt_d  = '0;
                    to_d    = 1'b1;
                    state_d = WAIT_B0;
                end else begin
                    tcnt_d  = tcnt_q + 1'b1;
                end
            end

            default: begin
                tcnt_d  = '0;
                state_d = WAIT_B0;
            end
        endcase
    end

    always_ff @(posedge i_driver_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= WAIT_B0;
            valid_prev_q <= 1'b0;
            tcnt_q       <= '0;
            hdr_q        <= '0;
            b1_q         <= '0;
            b2_q         <= '0;
            buttons_q    <= '0;
            dx_q         <= '0;
            dy_q         <= '0;
            pv_q         <= 1'b0;
            sync_q       <= 1'b0;
            to_q         <= 1'b0;
            cx_q         <= XW'(INIT_X);
            cy_q         <= YW'(INIT_Y);
        end else begin
            state_q      <= state_d;
            valid_prev_q <= bus.i_byte_valid;
            tcnt_q       <= tcnt_d;
            hdr_q        <= hdr_d;
            b1_q         <= b1_d;
            b2_q         <= b2_d;
            buttons_q    <= buttons_d;
            dx_q         <= dx_d;
            dy_q         <= dy_d;
            pv_q         <= pv_d;
            sync_q       <= sync_d;
            to_q         <= to_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
        end
    end

    assign bus.o_buttons      = buttons_q;
    assign bus.o_dx           = dx_q;
    assign bus.o_dy           = dy_q;
    assign bus.o_packet_valid = pv_q;
    assign bus.o_cursor_x     = cx_q;
    assign bus.o_cursor_y     = cy_q;
    assign bus.o_sync_err     = sync_q;
    assign bus.o_timeout      = to_q;
endmodule

// File: tb/tb_mouse_packet_decoder.sv
// Directed and randomized packet stimulus for mouse_packet_decoder, checked
// against an arithmetic model of packet decode and cursor clamping.
module tb_mouse_packet_decoder;
    localparam int T  = 2000;
    localparam int SW = 640;
    localparam int SH = 480;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mouse_packet_decoder_if #(.XW(10), .YW(9)) bus ();

    mouse_packet_decoder #(
        .SCREEN_W(SW), .SCREEN_H(SH), .INIT_X(320), .INIT_Y(240), .TIMEOUT_CYCLES(T)
    ) dut (
        .i_driver_clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int pv_cnt = 0, se_cnt = 0, to_cnt = 0, both_cnt = 0;

    // Reference state
    int mx = 320, my = 240, mbtn = 0, mdx = 0, mdy = 0;

    always @(negedge clk) begin
        if (bus.o_packet_valid === 1'b1) pv_cnt++;
        if (bus.o_sync_err === 1'b1) se_cnt++;
        if (bus.o_timeout === 1'b1) to_cnt++;
        if (bus.o_sync_err === 1'b1 && bus.o_timeout === 1'b1) both_cnt++;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic model_reset();
        mx = 320; my = 240; mbtn = 0; mdx = 0; mdy = 0;
    endtask

    task automatic model_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        mbtn = int'(b0[2:0]);
        mdx  = b0[6] ? 0 : (b0[4] ? int'(b1) - 256 : int'(b1));
        mdy  = b0[7] ? 0 : (b0[5] ? int'(b2) - 256 : int'(b2));
        mx   = clampi(mx + mdx, 0, SW - 1);
        my   = clampi(my - mdy, 0, SH - 1);
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
        @(negedge clk);
        bus.i_byte       = b;
        bus.i_byte_valid = 1'b1;
        repeat (hold) @(negedge clk);
        bus.i_byte_valid = 1'b0;
        bus.i_byte       = 8'($urandom);
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".btn"}, int'(bus.o_buttons), mbtn);
        chk({tag, ".dx"},  int'($signed(bus.o_dx)), mdx);
        chk({tag, ".dy"},  int'($signed(bus.o_dy)), mdy);
        chk({tag, ".x"},   int'(bus.o_cursor_x), mx);
        chk({tag, ".y"},   int'(bus.o_cursor_y), my);
    endtask

    task automatic do_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             input int hold, input int gap, input string tag);
        int p0, t0;
        p0 = pv_cnt;
        t0 = to_cnt;
        send_byte(b0, hold, gap);
        send_byte(b1, hold, gap);
        send_byte(b2, hold, gap);
        model_packet(b0, b1, b2);
        repeat (3) @(negedge clk);
        chk({tag, ".pv"}, pv_cnt - p0, 1);
        chk({tag, ".to"}, to_cnt - t0, 0);
        check_outputs(tag);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, s0, t0;
        logic [7:0] rb0, rb1, rb2, sb;

        bus.i_byte       = 8'h00;
        bus.i_byte_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        model_reset();
        check_outputs("rst");
        chk("rst.pv", int'(bus.o_packet_valid), 0);
        chk("rst.se", int'(bus.o_sync_err), 0);
        chk("rst.to", int'(bus.o_timeout), 0);

        // Reset in the middle of a packet
        do_packet(8'h09, 8'h07, 8'h04, 1, 2, "pre");
        p0 = pv_cnt;
        send_byte(8'h08, 1, 2);
        send_byte(8'h05, 1, 2);
        #2 rst_n = 1'b0;
        #13;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        check_outputs("midrst");
        chk("midrst.pv", pv_cnt - p0, 0);
        do_packet(8'h08, 8'h01, 8'h01, 1, 2, "afterrst");

        // Held-high strobe counts as a single byte
        rst_n = 1'b0;
        #7;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        do_packet(8'h09, 8'h05, 8'h03, 3, 2, "held");

        do_packet(8'h38, 8'hF6, 8'hFE, 2, 1, "neg");
        do_packet(8'h48, 8'h10, 8'h02, 1, 3, "xovf");

        do_packet(8'h18, 8'h00, 8'h00, 1, 2, "clampx1");
        do_packet(8'h18, 8'h00, 8'h00, 1, 2, "clampx2");
        do_packet(8'h28, 8'h00, 8'h00, 1, 2, "clampy1");
        do_packet(8'h28, 8'h00, 8'h00, 1, 2, "clampy2");

        // Rejected header byte
        s0 = se_cnt;
        p0 = pv_cnt;
        send_byte(8'h05, 1, 2);
        repeat (2) @(negedge clk);
        chk("sync.se", se_cnt - s0, 1);
        chk("sync.pv", pv_cnt - p0, 0);
        do_packet(8'h08, 8'h02, 8'h00, 1, 2, "aftersync");

        // Abandoned partial packet
        t0 = to_cnt;
        p0 = pv_cnt;
        send_byte(8'h08, 1, 1);
        repeat (T + 5) @(negedge clk);
        chk("tmo.to", to_cnt - t0, 1);
        chk("tmo.pv", pv_cnt - p0, 0);
        do_packet(8'h08, 8'h01, 8'h01, 1, 2, "aftertmo");

        // Slow but in-time bytes must not time out
        do_packet(8'h08, 8'h03, 8'h04, 1, T - 20, "slow");

        // Randomized packets, sometimes preceded by a junk header candidate
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                sb = 8'($urandom);
                sb[3] = 1'b0;
                s0 = se_cnt;
                send_byte(sb, $urandom_range(1, 3), $urandom_range(1, 3));
                repeat (2) @(negedge clk);
                chk($sformatf("rnd%0d.se", i), se_cnt - s0, 1);
            end
            rb0 = 8'($urandom);
            rb0[3] = 1'b1;
            rb1 = 8'($urandom);
            rb2 = 8'($urandom);
            do_packet(rb0, rb1, rb2, $urandom_range(1, 3), $urandom_range(1, 4),
                      $sformatf("rnd%0d", i));
        end

        chk("nooverlap", both_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
